div_seq: RTL
============

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 SHALL have parameter DIV_W, default 32, operand/result width.
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: resetn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  divide instruction present in Execute stage.
REQ-005 SHALL have port: signed_div  input  1  1 = DIV (signed), 0 = DIVU.
REQ-006 SHALL have port: opa  input  DIV_W  dividend (rs value after forwarding).
REQ-007 SHALL have port: opb  input  DIV_W  divisor (rt value after forwarding).
REQ-008 SHALL have port: annul  input  1  exception flush; abandons the current divide.
REQ-009 SHALL have port: stall_div  output  1  hold F/D/E stages; feeds hazard unit stall_divE.
REQ-010 SHALL have port: result_ready  output  1  quotient/remainder valid this cycle.
REQ-011 SHALL have port: quotient  output  DIV_W  LO write value.
REQ-012 SHALL have port: remainder  output  DIV_W  HI write value.

Function
REQ-013 SHALL implement states IDLE, BUSY and DONE.
REQ-014 SHALL, in IDLE with start=1, annul=0 and opb!=0, latch |opa|, |opb| and the signs, clear the iteration count and enter BUSY.
REQ-015 SHALL, in BUSY, perform one restoring shift-subtract step per cycle and enter DONE after DIV_W steps.
REQ-016 SHALL, in IDLE with start=1, annul=0 and opb=0, enter DONE directly with quotient all-ones and remainder=opa.
REQ-017 SHALL drive stall_div = ~annul & ((IDLE & start) | BUSY), combinationally.
REQ-018 SHALL keep stall_div high for exactly DIV_W+1 cycles (T..T+32 at DIV_W=32), from accept cycle T, for nonzero divisor.
REQ-019 SHALL keep stall_div high for exactly 1 cycle for a zero divisor.
REQ-020 SHALL, in DONE, drive stall_div=0 and result_ready=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-021 SHALL ignore start in BUSY and DONE; latched operands SHALL NOT change during BUSY.
REQ-022 SHALL, in signed mode, negate the quotient when the operand signs differ, and give the remainder the dividend's sign.
REQ-023 SHALL produce quotient 0x80000000, remainder 0 for signed 0x80000000 / 0xFFFFFFFF, with no trap.
REQ-024 SHALL, on annul=1 in any state, return to IDLE next edge with no result_ready; annul SHALL dominate a simultaneous start.
REQ-025 SHALL hold quotient/remainder stable outside DONE at their last value.

Reset
REQ-026 SHALL, on resetn low, immediately force IDLE, count=0, stall_div=0, result_ready=0, quotient=0 and remainder=0.
REQ-027 SHALL discard a divide in progress when reset is applied mid-operation; after release it SHALL wait for a new start.

Structure
REQ-028 SHALL take the state encoding, DIV_W default and divide-by-zero quotient constant from the shared CPU definitions package.
REQ-029 SHALL place one iteration step (shift, trial subtract, quotient-bit select) in a combinational sub-module div_step.
REQ-030 SHALL size the iteration counter as clog2(DIV_W) bits.

Verification
REQ-031 SHALL pass: DIVU 100/7 -> stall_div high 33 cycles; result_ready at T+33; quotient 14, remainder 2.
REQ-032 SHALL pass: DIV -7/2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
REQ-033 SHALL pass: DIV 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0.
REQ-034 SHALL pass: DIVU 5/0 -> stall_div high 1 cycle; next cycle result_ready=1, quotient 0xFFFFFFFF, remainder 5.
REQ-035 SHALL pass: annul at T+10 -> stall_div low that cycle, IDLE at T+11, no result_ready; a new start at T+12 is accepted normally.
REQ-036 SHALL pass: resetn low at T+5 -> stall_div, result_ready, quotient and remainder all 0 immediately; state IDLE after release.

Source files
------------

// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential divider: default width, the
// divide-by-zero quotient value and the controller state encoding.
package div_seq_pkg;

  localparam int DIV_W_DEF = 32;
  localparam int DIV_W_MAX = 64;

  // All-ones quotient for a zero divisor; users slice the low DIV_W bits.
  localparam logic [DIV_W_MAX-1:0] DIV0_QUOT = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_seq_step.sv
// One restoring divide iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, and select the quotient bit.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] quo_i,
  input  logic [W-1:0] dvsr_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] quo_o
);

  logic [W:0] shifted;
  logic [W:0] diff;

  always_comb begin
    shifted = {rem_i, quo_i[W-1]};
    diff    = shifted - {1'b0, dvsr_i};
    // A set MSB means the trial subtract went negative: restore.
    if (!diff[W]) begin
      rem_o = diff[W-1:0];
      quo_o = {quo_i[W-2:0], 1'b1};
    end else begin
      rem_o = shifted[W-1:0];
      quo_o = {quo_i[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle signed/unsigned divider for the Execute stage; stalls the
// front of the pipe while iterating and presents LO/HI for one cycle.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start; stall_div follows start combinationally
// BUSY    | one shift-subtract step per cycle, DIV_W steps in total
// DONE    | result_ready for one cycle, then back to IDLE
module div_seq
  import div_seq_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             signed_div,
  input  logic [DIV_W-1:0] opa,
  input  logic [DIV_W-1:0] opb,
  input  logic             annul,
  output logic             stall_div,
  output logic             result_ready,
  output logic [DIV_W-1:0] quotient,
  output logic [DIV_W-1:0] remainder
);

  localparam int              CNT_W    = $clog2(DIV_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  div_state_e       state_q;
  logic [CNT_W-1:0] count_q;
  logic [DIV_W-1:0] rem_q;
  logic [DIV_W-1:0] quo_q;
  logic [DIV_W-1:0] dvsr_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic [DIV_W-1:0] quotient_q;
  logic [DIV_W-1:0] remainder_q;

  logic             opa_neg;
  logic             opb_neg;
  logic [DIV_W-1:0] opa_mag;
  logic [DIV_W-1:0] opb_mag;
  logic [DIV_W-1:0] step_rem;
  logic [DIV_W-1:0] step_quo;
  logic [DIV_W-1:0] quotient_d;
  logic [DIV_W-1:0] remainder_d;

  always_comb begin
    opa_neg = signed_div & opa[DIV_W-1];
    opb_neg = signed_div & opb[DIV_W-1];
    opa_mag = opa_neg ? -opa : opa;
    opb_mag = opb_neg ? -opb : opb;
  end

  div_step #(
    .W (DIV_W)
  ) u_step (
    .rem_i  (rem_q),
    .quo_i  (quo_q),
    .dvsr_i (dvsr_q),
    .rem_o  (step_rem),
    .quo_o  (step_quo)
  );

  // Sign fix-up applied to the final step's outputs as they are captured;
  // the most-negative / -1 case wraps back to itself, so no trap is needed.
  always_comb begin
    quotient_d  = neg_quo_q ? -step_quo : step_quo;
    remainder_d = neg_rem_q ? -step_rem : step_rem;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvsr_q      <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !annul) begin
            if (opb == '0) begin
              state_q     <= ST_DONE;
              quotient_q  <= DIV0_QUOT[DIV_W-1:0];
              remainder_q <= opa;
            end else begin
              state_q   <= ST_BUSY;
              count_q   <= '0;
              rem_q     <= '0;
              quo_q     <= opa_mag;
              dvsr_q    <= opb_mag;
              neg_quo_q <= opa_neg ^ opb_neg;
              neg_rem_q <= opa_neg;
            end
          end
        end
        ST_BUSY: begin
          if (annul) begin
            state_q <= ST_IDLE;
          end else begin
            rem_q   <= step_rem;
            quo_q   <= step_quo;
            count_q <= count_q + CNT_ONE;
            if (count_q == CNT_LAST) begin
              state_q     <= ST_DONE;
              quotient_q  <= quotient_d;
              remainder_q <= remainder_d;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // resetn gating keeps stall low while reset is held even if start is up.
  assign stall_div    = resetn & ~annul &
                        (((state_q == ST_IDLE) & start) | (state_q == ST_BUSY));
  assign result_ready = (state_q == ST_DONE);
  assign quotient     = quotient_q;
  assign remainder    = remainder_q;

endmodule
